alu_decoder: RTL and testbench

Combinational ALU-control decoder for the data-processing path of the single-cycle ARM-subset CPU controller. It maps the main decoder's `alu_op` enable, the instruction S bit and the 4-bit cmd field to the ALU operation select, flag-write enables, a register-write suppress, a shifter-select and an undefined-opcode indication. A registered copy of every decode output is also provided for pipelined or multicycle consumers; it is clocked by the single core clock.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_decode_reg.sv | 23 ++
 rtl/alu_decoder.sv | 87 ++++++++
 tb/tb_alu_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the data-processing ALU control path.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    ORR = 2'b11
  } alu_ctl_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_NZCV = 2'b11;

  typedef struct packed {
    alu_ctl_t   alu_ctl;
    logic [1:0] flag_w;
    logic       no_write;
    logic       shift;
    logic       undef;
  } decode_t;

  // Flag writes gated by the S bit.
  function automatic logic [1:0] fw_if_s(input logic s, input logic [1:0] fw);
    return s ? fw : FW_NONE;
  endfunction

endpackage

// File: rtl/alu_decode_reg.sv
// Registered copy of the ALU decode outputs, cleared by an asynchronous reset.
module alu_decode_reg
  import alu_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  decode_t d,
  output decode_t q
);

  decode_t q_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu_decoder.sv
// ALU-control decoder: maps alu_op, S bit and cmd to ALU select and side controls,
// with a registered copy of every output.
module alu_decoder
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_op,
  input  logic       s,
  input  logic [3:0] cmd,
  output logic [1:0] alu_ctl,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       shift,
  output logic       undef,
  output logic [1:0] alu_ctl_q,
  output logic [1:0] flag_w_q,
  output logic       no_write_q,
  output logic       shift_q,
  output logic       undef_q
);

  decode_t dec;
  decode_t dec_q;

  always_comb begin
    dec = '{alu_ctl: ADD, flag_w: FW_NONE, no_write: 1'b0, shift: 1'b0, undef: 1'b0};
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin
          dec.alu_ctl = ADD;
          dec.flag_w  = fw_if_s(s, FW_NZCV);
        end
        CMD_SUB: begin
          dec.alu_ctl = SUB;
          dec.flag_w  = fw_if_s(s, FW_NZCV);
        end
        CMD_AND: begin
          dec.alu_ctl = AND;
          dec.flag_w  = fw_if_s(s, FW_NZ);
        end
        CMD_ORR: begin
          dec.alu_ctl = ORR;
          dec.flag_w  = fw_if_s(s, FW_NZ);
        end
        // Compares always update flags and never write back.
        CMD_CMP: begin
          dec.alu_ctl  = SUB;
          dec.flag_w   = FW_NZCV;
          dec.no_write = 1'b1;
        end
        CMD_TST: begin
          dec.alu_ctl  = AND;
          dec.flag_w   = FW_NZ;
          dec.no_write = 1'b1;
        end
        CMD_MOV: begin
          dec.alu_ctl = ADD;
          dec.flag_w  = fw_if_s(s, FW_NZ);
          dec.shift   = 1'b1;
        end
        default: begin
          dec.undef = 1'b1;
        end
      endcase
    end
  end

  alu_decode_reg u_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dec),
    .q       (dec_q)
  );

  assign alu_ctl    = dec.alu_ctl;
  assign flag_w     = dec.flag_w;
  assign no_write   = dec.no_write;
  assign shift      = dec.shift;
  assign undef      = dec.undef;
  assign alu_ctl_q  = dec_q.alu_ctl;
  assign flag_w_q   = dec_q.flag_w;
  assign no_write_q = dec_q.no_write;
  assign shift_q    = dec_q.shift;
  assign undef_q    = dec_q.undef;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: stimulus queues expected words, a monitor checks them.
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_op;
  logic       s;
  logic [3:0] cmd;
  logic [1:0] alu_ctl, flag_w, alu_ctl_q, flag_w_q;
  logic       no_write, shift, undef, no_write_q, shift_q, undef_q;

  alu_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_op     (alu_op),
    .s          (s),
    .cmd        (cmd),
    .alu_ctl    (alu_ctl),
    .flag_w     (flag_w),
    .no_write   (no_write),
    .shift      (shift),
    .undef      (undef),
    .alu_ctl_q  (alu_ctl_q),
    .flag_w_q   (flag_w_q),
    .no_write_q (no_write_q),
    .shift_q    (shift_q),
    .undef_q    (undef_q)
  );

  always #5 clk = ~clk;

  // Packed view: {alu_ctl, flag_w, no_write, shift, undef}
  logic [6:0] comb_bus, q_bus;
  assign comb_bus = {alu_ctl, flag_w, no_write, shift, undef};
  assign q_bus    = {alu_ctl_q, flag_w_q, no_write_q, shift_q, undef_q};

  typedef struct {
    bit         is_reg;
    logic [6:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  logic req = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [6:0] pk(input logic [1:0] ctl, input logic [1:0] fw,
                                    input logic nw, input logic sh, input logic ud);
    return {ctl, fw, nw, sh, ud};
  endfunction

  // Reference table for the full (s, cmd) sweep with alu_op=1.
  function automatic logic [6:0] model(input logic sb_s, input logic [3:0] c);
    case (c)
      4'b0100: return pk(2'b00, sb_s ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0);
      4'b0010: return pk(2'b01, sb_s ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0);
      4'b0000: return pk(2'b10, sb_s ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0);
      4'b1100: return pk(2'b11, sb_s ? 2'b10 : 2'b00, 1'b0, 1'b0, 1'b0);
      4'b1010: return pk(2'b01, 2'b11, 1'b1, 1'b0, 1'b0);
      4'b1000: return pk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
      4'b1101: return pk(2'b00, sb_s ? 2'b10 : 2'b00, 1'b0, 1'b1, 1'b0);
      default: return pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    endcase
  endfunction

  // Monitor: samples 1 time unit after each request strobe.
  initial begin
    exp_t       e;
    logic [6:0] got;
    forever begin
      @(posedge req);
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: no expected entry queued");
      end else begin
        e   = sb.pop_front();
        got = e.is_reg ? q_bus : comb_bus;
        if (got === e.val) n_pass++;
        else $display("FAIL %s: got %b, expected %b", e.name, got, e.val);
      end
    end
  end

  task automatic issue(input bit is_reg, input logic [6:0] v, input string nm);
    sb.push_back('{is_reg: is_reg, val: v, name: nm});
    req = 1'b1;
    #2;
    req = 1'b0;
    #1;
  endtask

  task automatic drive(input logic op, input logic sv, input logic [3:0] c);
    @(negedge clk);
    alu_op = op;
    s      = sv;
    cmd    = c;
  endtask

  typedef struct {
    logic       op;
    logic       sv;
    logic [3:0] c;
    logic [6:0] e;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1'b0, 1'b1, 4'b0100, pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0), "non_dp"},
      '{1'b1, 1'b0, 4'b0100, pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0), "add_s0"},
      '{1'b1, 1'b1, 4'b0100, pk(2'b00, 2'b11, 1'b0, 1'b0, 1'b0), "add_s1"},
      '{1'b1, 1'b0, 4'b0010, pk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0), "sub_s0"},
      '{1'b1, 1'b1, 4'b0010, pk(2'b01, 2'b11, 1'b0, 1'b0, 1'b0), "sub_s1"},
      '{1'b1, 1'b0, 4'b0000, pk(2'b10, 2'b00, 1'b0, 1'b0, 1'b0), "and_s0"},
      '{1'b1, 1'b1, 4'b0000, pk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0), "and_s1"},
      '{1'b1, 1'b0, 4'b1100, pk(2'b11, 2'b00, 1'b0, 1'b0, 1'b0), "orr_s0"},
      '{1'b1, 1'b1, 4'b1100, pk(2'b11, 2'b10, 1'b0, 1'b0, 1'b0), "orr_s1"},
      '{1'b1, 1'b1, 4'b1010, pk(2'b01, 2'b11, 1'b1, 1'b0, 1'b0), "cmp_s1"},
      '{1'b1, 1'b0, 4'b1010, pk(2'b01, 2'b11, 1'b1, 1'b0, 1'b0), "cmp_s0"},
      '{1'b1, 1'b1, 4'b1000, pk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0), "tst_s1"},
      '{1'b1, 1'b0, 4'b1000, pk(2'b10, 2'b10, 1'b1, 1'b0, 1'b0), "tst_s0"},
      '{1'b1, 1'b0, 4'b1101, pk(2'b00, 2'b00, 1'b0, 1'b1, 1'b0), "lsl_s0"},
      '{1'b1, 1'b1, 4'b1101, pk(2'b00, 2'b10, 1'b0, 1'b1, 1'b0), "lsl_s1"},
      '{1'b1, 1'b0, 4'b0111, pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1), "undef_0111"},
      '{1'b0, 1'b0, 4'b0111, pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0), "non_dp_undef_cmd"}
    };

    reset_n = 1'b0;
    alu_op  = 1'b1;
    s       = 1'b1;
    cmd     = 4'b0100;
    #2;
    issue(1'b1, 7'b0, "q_reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].sv, vecs[i].c);
      issue(1'b0, vecs[i].e, vecs[i].nm);
    end

    for (int k = 0; k < 32; k++) begin
      logic [4:0] sc;
      sc = 5'(k);
      drive(1'b1, sc[4], sc[3:0]);
      issue(1'b0, model(sc[4], sc[3:0]), $sformatf("sweep_s%0d_cmd%b", sc[4], sc[3:0]));
    end

    // Register bank: one-edge latency, async clear, synchronous release.
    drive(1'b1, 1'b1, 4'b0100);
    @(posedge clk);
    #1;
    issue(1'b1, pk(2'b00, 2'b11, 1'b0, 1'b0, 1'b0), "q_add_s1_after_edge");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    issue(1'b1, 7'b0, "q_async_reset");
    issue(1'b0, pk(2'b00, 2'b11, 1'b0, 1'b0, 1'b0), "comb_during_reset");
    @(posedge clk);
    #1;
    issue(1'b1, 7'b0, "q_held_in_reset");
    drive(1'b1, 1'b0, 4'b1010);
    reset_n = 1'b1;
    #1;
    issue(1'b1, 7'b0, "q_no_update_before_edge");
    @(posedge clk);
    #1;
    issue(1'b1, pk(2'b01, 2'b11, 1'b1, 1'b0, 1'b0), "q_cmp_after_release");

    for (int t = 0; t < 50 && sb.size() != 0; t++) #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
